uart_cmd_dispatch: RTL and testbench

//  Parametrised UART command-frame parser and dispatcher for the stepper channels.

---
 rtl/vert_cpld_defs.sv | 16 +
 rtl/cmd_slot.sv | 32 +++
 rtl/uart_cmd_dispatch.sv | 155 +++++++++++++++
 tb/tb_uart_cmd_dispatch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vert_cpld_defs.sv
// Shared definitions for the vertical CPLD command path: byte width,
// default channel geometry and the command parser state encoding.
package vert_cpld_defs;

   localparam int BYTE_W     = 8;
   localparam int DEF_NUM_CH = 10;
   localparam int DEF_WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PAY    = 2'd1,
      ST_CSUM   = 2'd2,
      ST_COMMIT = 2'd3
   } parse_state_t;

endpackage

// File: rtl/cmd_slot.sv
// One motor channel mailbox: holds the last committed word and its pending
// flag, and tells the parser whether a new word would overwrite an unread one.
module cmd_slot #(
   parameter int WORD_W = 32
) (
   input  logic              CLK_SE_AR,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] loadWord,
   input  logic              ack,
   output logic [WORD_W-1:0] word,
   output logic              valid,
   output logic              full
);

   // Ack in the same cycle as a load lets the load win, so valid stays set.
   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge CLK_SE_AR or posedge rst) begin
      if (rst) begin
         word  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         word  <= loadWord;
         valid <= 1'b1;
      end else if (ack && valid) begin
         valid <= 1'b0;
      end
   end

   assign full = valid & ~ack;

endmodule

// File: rtl/uart_cmd_dispatch.sv
// UART command-frame parser: {header, WORD_W/8 payload bytes LSB first} to per-channel
// mailboxes. Optional trailing XOR checksum byte when UART_CMD_CSUM_EN is defined.
module uart_cmd_dispatch
   import vert_cpld_defs::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int CH_W        = 4,
   parameter int WORD_W      = DEF_WORD_W,
   parameter int TIMEOUT_CYC = 2400,
   parameter int CNT_W       = 16
) (
   input  logic                     CLK_SE_AR,
   input  logic                     rst,
   input  logic                     rx_ready,
   input  logic [BYTE_W-1:0]        rx_data,
   output logic [NUM_CH*WORD_W-1:0] cmd_data,
   output logic [NUM_CH-1:0]        cmd_valid,
   input  logic [NUM_CH-1:0]        cmd_ack,
   output logic                     frame_ok,
   output logic                     err_chan,
   output logic                     err_ovr,
   output logic                     err_tmo,
   output logic                     err_csum,
   output logic [CNT_W-1:0]         frame_cnt
);

   localparam int NBYTES = WORD_W / BYTE_W;
   localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);

   parse_state_t      state, stateNext;
   logic              rxReadyQ, byteStb, inFrame, tmoHit, lastPay;
   logic [CH_W-1:0]   chanQ;
   logic              badQ;
   logic [BC_W-1:0]   byteCnt;
   logic [WORD_W-1:0] shiftWord;
   logic [TMR_W-1:0]  timer;
   logic [NUM_CH-1:0] chanHit, slotFull, slotLoad;
   logic              commitBad, commitOvr, commitOk;
   logic [WORD_W-1:0] slotWord [NUM_CH];

   assign byteStb = rx_ready & ~rxReadyQ;
   assign inFrame = (state == ST_PAY) || (state == ST_CSUM);
   assign tmoHit  = inFrame && (timer == TMR_W'(TIMEOUT_CYC - 1));
   assign lastPay = (byteCnt == BC_W'(NBYTES - 1));

`ifdef UART_CMD_CSUM_EN
   logic [BYTE_W-1:0] csumQ;
   logic              csumBad;
   assign csumBad = (state == ST_CSUM) && byteStb && !tmoHit && (rx_data != csumQ);
`else
   assign err_csum = 1'b0;
`endif

   always_ff @(posedge CLK_SE_AR or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= stateNext;
   end

   // NOTE: default assigned first so no path through the case can infer a latch.
   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE: if (byteStb) stateNext = ST_PAY;
         ST_PAY: begin
            if (tmoHit) stateNext = ST_IDLE;
            else if (byteStb && lastPay) begin
`ifdef UART_CMD_CSUM_EN
               stateNext = ST_CSUM;
`else
               stateNext = ST_COMMIT;
`endif
            end
         end
`ifdef UART_CMD_CSUM_EN
         ST_CSUM: begin
            if (tmoHit) stateNext = ST_IDLE;
            else if (byteStb) stateNext = (rx_data == csumQ) ? ST_COMMIT : ST_IDLE;
         end
`endif
         ST_COMMIT: stateNext = ST_IDLE;
         default:   stateNext = ST_IDLE;
      endcase
   end

   assign commitBad = (state == ST_COMMIT) && badQ;
   assign commitOvr = (state == ST_COMMIT) && !badQ && |(chanHit & slotFull);
   assign commitOk  = (state == ST_COMMIT) && !badQ && !(|(chanHit & slotFull));

   // NOTE: rxReadyQ resets to 1 so a level already high when reset drops is not taken as a byte.
   always_ff @(posedge CLK_SE_AR or posedge rst) begin
      if (rst) begin
         rxReadyQ  <= 1'b1;
         chanQ     <= '0;
         badQ      <= 1'b0;
         byteCnt   <= '0;
         shiftWord <= '0;
         timer     <= '0;
         frame_ok  <= 1'b0;
         err_chan  <= 1'b0;
         err_ovr   <= 1'b0;
         err_tmo   <= 1'b0;
         frame_cnt <= '0;
`ifdef UART_CMD_CSUM_EN
         csumQ     <= '0;
         err_csum  <= 1'b0;
`endif
      end else begin
         rxReadyQ <= rx_ready;
         timer    <= (inFrame && !byteStb && !tmoHit) ? timer + 1'b1 : '0;
         if (state == ST_IDLE && byteStb) begin
            chanQ   <= rx_data[CH_W-1:0];
            badQ    <= (rx_data >= BYTE_W'(NUM_CH));
            byteCnt <= '0;
`ifdef UART_CMD_CSUM_EN
            csumQ   <= rx_data;
`endif
         end
         // A strobe coinciding with the timeout is dropped with the partial frame.
         if (state == ST_PAY && byteStb && !tmoHit) begin
            shiftWord <= (shiftWord >> BYTE_W) | (WORD_W'(rx_data) << (WORD_W - BYTE_W));
            byteCnt   <= byteCnt + 1'b1;
`ifdef UART_CMD_CSUM_EN
            csumQ     <= csumQ ^ rx_data;
`endif
         end
         frame_ok <= commitOk;
         err_chan <= commitBad;
         err_ovr  <= commitOvr;
         err_tmo  <= tmoHit;
`ifdef UART_CMD_CSUM_EN
         err_csum <= csumBad;
`endif
         if (commitOk) frame_cnt <= frame_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : gSlot
      assign chanHit[i]  = (chanQ == CH_W'(i));
      assign slotLoad[i] = commitOk & chanHit[i];
      assign cmd_data[i*WORD_W +: WORD_W] = slotWord[i];

      cmd_slot #(.WORD_W(WORD_W)) uSlot (
         .CLK_SE_AR (CLK_SE_AR),
         .rst       (rst),
         .load      (slotLoad[i]),
         .loadWord  (shiftWord),
         .ack       (cmd_ack[i]),
         .word      (slotWord[i]),
         .valid     (cmd_valid[i]),
         .full      (slotFull[i])
      );
   end

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Self-checking bench for uart_cmd_dispatch: directed frame table, timeout and reset
// corners, then randomized traffic against a mailbox-level model.
module tb_uart_cmd_dispatch;

   localparam int NUM_CH = 10;
   localparam int CH_W   = 4;
   localparam int WORD_W = 32;
   localparam int NB     = WORD_W / 8;
   localparam int TO     = 64;
   localparam int CNT_W  = 16;
   localparam int K_OK   = 0;
   localparam int K_OVR  = 1;
   localparam int K_CHAN = 2;

   logic                     CLK_SE_AR = 1'b0;
   logic                     rst;
   logic                     rx_ready;
   logic [7:0]               rx_data;
   logic [NUM_CH*WORD_W-1:0] cmd_data;
   logic [NUM_CH-1:0]        cmd_valid;
   logic [NUM_CH-1:0]        cmd_ack;
   logic                     frame_ok, err_chan, err_ovr, err_tmo, err_csum;
   logic [CNT_W-1:0]         frame_cnt;

   uart_cmd_dispatch #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .WORD_W(WORD_W), .TIMEOUT_CYC(TO), .CNT_W(CNT_W)
   ) dut (
      .CLK_SE_AR (CLK_SE_AR),
      .rst       (rst),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid),
      .cmd_ack   (cmd_ack),
      .frame_ok  (frame_ok),
      .err_chan  (err_chan),
      .err_ovr   (err_ovr),
      .err_tmo   (err_tmo),
      .err_csum  (err_csum),
      .frame_cnt (frame_cnt)
   );

   always #5 CLK_SE_AR = ~CLK_SE_AR;

   int nVec = 0;
   int nMis = 0;

   // Pulse counters sampled away from the active edge.
   int okSeen = 0, chanSeen = 0, ovrSeen = 0, tmoSeen = 0, csumSeen = 0;
   always @(negedge CLK_SE_AR) begin
      if (frame_ok) okSeen++;
      if (err_chan) chanSeen++;
      if (err_ovr)  ovrSeen++;
      if (err_tmo)  tmoSeen++;
      if (err_csum) csumSeen++;
   end

   // Mailbox-level reference model.
   logic [NUM_CH-1:0] expValid = '0;
   logic [WORD_W-1:0] expData [NUM_CH];
   int expCnt = 0, expOk = 0, expChan = 0, expOvr = 0, expTmo = 0, expCsum = 0;

   function automatic void model_reset();
      expValid = '0;
      for (int i = 0; i < NUM_CH; i++) expData[i] = '0;
      expCnt = 0;
   endfunction

   function automatic void model_frame(input logic [7:0] hdr, input logic [WORD_W-1:0] w,
                                       input bit ack, input bit badCsum);
      int ch;
      ch = int'(hdr);
      if (badCsum) begin
         expCsum++;
         if (ack && ch < NUM_CH) expValid[ch] = 1'b0;
      end else if (ch >= NUM_CH) begin
         expChan++;
      end else if (expValid[ch] && !ack) begin
         expOvr++;
      end else begin
         expValid[ch] = 1'b1;
         expData[ch]  = w;
         expOk++;
         expCnt++;
      end
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_state(input string tag, input int ch);
      check({tag, ".valid"}, 64'(cmd_valid), 64'(expValid));
      check({tag, ".cnt"},   64'(frame_cnt), 64'(CNT_W'(expCnt)));
      check({tag, ".ok"},    64'(okSeen),    64'(expOk));
      check({tag, ".chan"},  64'(chanSeen),  64'(expChan));
      check({tag, ".ovr"},   64'(ovrSeen),   64'(expOvr));
      check({tag, ".tmo"},   64'(tmoSeen),   64'(expTmo));
      check({tag, ".csum"},  64'(csumSeen),  64'(expCsum));
      if (ch < NUM_CH && expValid[ch])
         check({tag, ".data"}, 64'(cmd_data[ch*WORD_W +: WORD_W]), 64'(expData[ch]));
   endtask

   // One byte: rx_ready rises at a negedge, drops one cycle later, then gap idle cycles.
   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge CLK_SE_AR);
      rx_data  = b;
      rx_ready = 1'b1;
      @(negedge CLK_SE_AR);
      rx_ready = 1'b0;
      repeat (gap) @(negedge CLK_SE_AR);
   endtask

   // Returns during the COMMIT cycle (final byte sent with no trailing gap).
   task automatic send_frame(input logic [7:0] hdr, input logic [WORD_W-1:0] w,
                             input bit badCsum, input int gap);
`ifdef UART_CMD_CSUM_EN
      logic [7:0] x;
      x = hdr;
      send_byte(hdr, gap);
      for (int i = 0; i < NB; i++) begin
         x ^= w[i*8 +: 8];
         send_byte(w[i*8 +: 8], gap);
      end
      send_byte(badCsum ? (x ^ 8'h5A) : x, 0);
`else
      if (badCsum) $display("note: checksum corruption requested without checksum build");
      send_byte(hdr, gap);
      for (int i = 0; i < NB; i++)
         send_byte(w[i*8 +: 8], (i == NB - 1) ? 0 : gap);
`endif
   endtask

   typedef struct {
      logic [7:0]  hdr;
      logic [31:0] word;
      bit          ack;
      int          kind;
      int          cnt;
   } vec_t;

   initial begin
      vec_t vecs [8];
      int   o0, v0, c0;
      bit   wasValid;
      int   ch;

      vecs = '{
         '{8'h03, 32'h12345678, 1'b0, K_OK,   1},
         '{8'h03, 32'hAABBCCDD, 1'b0, K_OVR,  1},
         '{8'h03, 32'hCAFEF00D, 1'b1, K_OK,   2},
         '{8'h0C, 32'h11111111, 1'b0, K_CHAN, 2},
         '{8'h09, 32'hDEADBEEF, 1'b0, K_OK,   3},
         '{8'h0A, 32'h22222222, 1'b0, K_CHAN, 3},
         '{8'h13, 32'h33333333, 1'b0, K_CHAN, 3},
         '{8'h00, 32'h00000001, 1'b0, K_OK,   4}
      };

      rst = 1'b1; rx_ready = 1'b0; rx_data = '0; cmd_ack = '0;
      model_reset();
      repeat (3) @(negedge CLK_SE_AR);
      check("reset.valid", 64'(cmd_valid), 64'd0);
      check("reset.data",  64'(|cmd_data), 64'd0);
      check("reset.flags", 64'({frame_ok, err_chan, err_ovr, err_tmo, err_csum}), 64'd0);
      rst = 1'b0;
      repeat (3) @(negedge CLK_SE_AR);
      check_state("idle", NUM_CH);

      // Directed frame table.
      foreach (vecs[k]) begin
         ch = int'(vecs[k].hdr);
         wasValid = (ch < NUM_CH) ? expValid[ch] : 1'b0;
         o0 = okSeen; v0 = ovrSeen; c0 = chanSeen;
         send_frame(vecs[k].hdr, vecs[k].word, 1'b0, 1);
         if (vecs[k].kind == K_OK && !wasValid)
            check($sformatf("v%0d.lat_early", k), 64'(cmd_valid[ch]), 64'd0);
         if (vecs[k].ack) cmd_ack[ch] = 1'b1;
         @(negedge CLK_SE_AR);
         cmd_ack = '0;
         if (vecs[k].kind == K_OK)
            check($sformatf("v%0d.lat_ok", k), 64'(frame_ok), 64'd1);
         model_frame(vecs[k].hdr, vecs[k].word, vecs[k].ack, 1'b0);
         repeat (2) @(negedge CLK_SE_AR);
         check($sformatf("v%0d.cnt", k),  64'(frame_cnt), 64'(vecs[k].cnt));
         check($sformatf("v%0d.ok", k),   64'(okSeen - o0),   64'(vecs[k].kind == K_OK));
         check($sformatf("v%0d.ovr", k),  64'(ovrSeen - v0),  64'(vecs[k].kind == K_OVR));
         check($sformatf("v%0d.chan", k), 64'(chanSeen - c0), 64'(vecs[k].kind == K_CHAN));
         check_state($sformatf("v%0d", k), ch);
      end
      check("v.ch3_word", 64'(cmd_data[3*WORD_W +: WORD_W]), 64'h00000000CAFEF00D);

      // Partial frame abandoned after silence, then a full frame to ch1.
      send_byte(8'h01, 0); send_byte(8'hA1, 0); send_byte(8'hA2, 0);
      repeat (TO + 4) @(negedge CLK_SE_AR);
      expTmo++;
      check_state("tmo", NUM_CH);
      send_frame(8'h01, 32'h0BADF00D, 1'b0, 1);
      model_frame(8'h01, 32'h0BADF00D, 1'b0, 1'b0);
      repeat (3) @(negedge CLK_SE_AR);
      check_state("tmo.next", 1);

      // Longest permitted inter-byte gap still completes a frame.
      send_frame(8'h04, 32'h44332211, 1'b0, TO - 3);
      model_frame(8'h04, 32'h44332211, 1'b0, 1'b0);
      repeat (3) @(negedge CLK_SE_AR);
      check_state("gapmax", 4);

      // Byte arriving in the timeout cycle is lost with the frame.
      send_byte(8'h05, 0); send_byte(8'h55, TO - 2); send_byte(8'h66, 0);
      repeat (TO + 4) @(negedge CLK_SE_AR);
      expTmo++;
      check_state("tmo.lost", NUM_CH);
      send_frame(8'h05, 32'h87654321, 1'b0, 0);
      model_frame(8'h05, 32'h87654321, 1'b0, 1'b0);
      repeat (3) @(negedge CLK_SE_AR);
      check_state("tmo.lost.next", 5);

`ifdef UART_CMD_CSUM_EN
      send_byte(8'h02, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
      send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h03, 0);
      model_frame(8'h02, 32'h1, 1'b0, 1'b0);
      repeat (3) @(negedge CLK_SE_AR);
      check_state("csum.good", 2);
      check("csum.good.word", 64'(cmd_data[2*WORD_W +: WORD_W]), 64'h1);
      send_byte(8'h02, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
      send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 0);
      model_frame(8'h02, 32'h1, 1'b0, 1'b1);
      repeat (3) @(negedge CLK_SE_AR);
      check_state("csum.bad", 2);
`endif

      // Reset mid-frame with rx_ready held high across release.
      send_byte(8'h06, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
      @(negedge CLK_SE_AR);
      rst = 1'b1;
      rx_ready = 1'b1;
      rx_data = 8'h01;
      @(negedge CLK_SE_AR);
      model_reset();
      check("rst.valid", 64'(cmd_valid), 64'd0);
      check("rst.data",  64'(|cmd_data), 64'd0);
      check("rst.cnt",   64'(frame_cnt), 64'd0);
      @(negedge CLK_SE_AR);
      rst = 1'b0;
      repeat (4) @(negedge CLK_SE_AR);
      rx_ready = 1'b0;
      repeat (2) @(negedge CLK_SE_AR);
      send_frame(8'h01, 32'hFEEDC0DE, 1'b0, 1);
      model_frame(8'h01, 32'hFEEDC0DE, 1'b0, 1'b0);
      repeat (3) @(negedge CLK_SE_AR);
      check_state("rst.next", 1);

      // Randomized traffic.
      for (int it = 0; it < 80; it++) begin
         int act, gap, nPay;
         logic [7:0] hdr;
         logic [WORD_W-1:0] w;
         logic [NUM_CH-1:0] a;
         bit ack, bc;
         act = $urandom_range(0, 9);
         hdr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, NUM_CH - 1));
         w   = $urandom;
         gap = $urandom_range(0, 3);
         if (act <= 5 || act == 9) begin
            ack = (act == 9) && (int'(hdr) < NUM_CH);
`ifdef UART_CMD_CSUM_EN
            bc = ($urandom_range(0, 5) == 0);
`else
            bc = 1'b0;
`endif
            send_frame(hdr, w, bc, gap);
            if (ack) cmd_ack[hdr[CH_W-1:0]] = 1'b1;
            @(negedge CLK_SE_AR);
            cmd_ack = '0;
            model_frame(hdr, w, ack, bc);
         end else if (act <= 7) begin
            a = NUM_CH'($urandom);
            cmd_ack = a;
            @(negedge CLK_SE_AR);
            cmd_ack = '0;
            expValid &= ~a;
         end else begin
            nPay = $urandom_range(0, NB - 1);
            send_byte(hdr, gap);
            for (int j = 0; j < nPay; j++) send_byte(8'($urandom), gap);
            repeat (TO + 2) @(negedge CLK_SE_AR);
            expTmo++;
         end
         repeat (3) @(negedge CLK_SE_AR);
         check_state($sformatf("rnd%0d", it), int'(hdr));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
